// File: rtl/stopwatch_controller.sv
// Stopwatch controller: button edge detect, RUN/PAUSED FSM,
// ms prescaler, packed h/m/s/ms counter and lap hold mux.
module stopwatch_controller #(
  parameter int TICKS_PER_MS = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        lap_reset,
  output logic [26:0] time_out,
  output logic        running,
  output logic        lap_hold,
  output logic [3:0]  lap_count,
  output logic        wrapped
);

  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_MS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED
  } state_t;

  state_t        state, state_n;
  logic [1:0]    in_q, in_qq;
  logic          ss_ev, lr_ev;
  logic          tick;
  logic          day_wrap;
  logic [PW-1:0] presc, presc_n;
  logic [26:0]   count, count_n, count_inc;
  logic [26:0]   lap_reg, lap_reg_n;
  logic          hold_n, wrap_n;
  logic [3:0]    laps_n;

  // start_stop wins a same-cycle collision; lap_reset is dropped
  assign ss_ev = in_q[0] & ~in_qq[0];
  assign lr_ev = in_q[1] & ~in_qq[1] & ~ss_ev;
  assign tick  = (state == RUN) && (presc == PMAX);

  // one-ms increment of the packed time with field carries
  always_comb begin
    count_inc = count;
    day_wrap  = 1'b0;
    if (count[9:0] != 10'd999) begin
      count_inc[9:0] = count[9:0] + 10'd1;
    end else begin
      count_inc[9:0] = 10'd0;
      if (count[15:10] != 6'd59) begin
        count_inc[15:10] = count[15:10] + 6'd1;
      end else begin
        count_inc[15:10] = 6'd0;
        if (count[21:16] != 6'd59) begin
          count_inc[21:16] = count[21:16] + 6'd1;
        end else begin
          count_inc[21:16] = 6'd0;
          if (count[26:22] != 5'd23) begin
            count_inc[26:22] = count[26:22] + 5'd1;
          end else begin
            count_inc[26:22] = 5'd0;
            day_wrap         = 1'b1;
          end
        end
      end
    end
  end

  // next state, prescaler, counter and lap bookkeeping
  always_comb begin
    state_n   = state;
    presc_n   = presc;
    count_n   = count;
    lap_reg_n = lap_reg;
    hold_n    = lap_hold;
    laps_n    = lap_count;
    wrap_n    = wrapped;
    if (state == RUN) begin
      presc_n = tick ? '0 : presc + 1'b1;
      if (tick) begin
        count_n = count_inc;
        if (day_wrap) wrap_n = 1'b1;
      end
    end
    unique case (1'b1)
      (state == IDLE): begin
        if (ss_ev) state_n = RUN;
      end
      (state == RUN): begin
        if (ss_ev) begin
          state_n = PAUSED;
          hold_n  = 1'b0;
        end else if (lr_ev) begin
          if (!lap_hold) begin
            lap_reg_n = count_n;
            hold_n    = 1'b1;
            if (lap_count != 4'd15) laps_n = lap_count + 4'd1;
          end else begin
            hold_n = 1'b0;
          end
        end
      end
      (state == PAUSED): begin
        if (ss_ev) begin
          state_n = RUN;
        end else if (lr_ev) begin
          state_n   = IDLE;
          presc_n   = '0;
          count_n   = '0;
          lap_reg_n = '0;
          hold_n    = 1'b0;
          laps_n    = 4'd0;
          wrap_n    = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state and registered outputs, synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      in_q      <= 2'b00;
      in_qq     <= 2'b00;
      presc     <= '0;
      count     <= '0;
      lap_reg   <= '0;
      lap_hold  <= 1'b0;
      lap_count <= 4'd0;
      wrapped   <= 1'b0;
      running   <= 1'b0;
      time_out  <= '0;
    end else begin
      state     <= state_n;
      in_q      <= {lap_reset, start_stop};
      in_qq     <= in_q;
      presc     <= presc_n;
      count     <= count_n;
      lap_reg   <= lap_reg_n;
      lap_hold  <= hold_n;
      lap_count <= laps_n;
      wrapped   <= wrap_n;
      running   <= (state_n == RUN);
      time_out  <= hold_n ? lap_reg_n : count_n;
    end
  end

endmodule
